// File: rtl/spi_reg_mux_n_if.sv
// Host-side SPI pins plus the register-file and channel-mux outputs
// of spi_reg_mux_n, bundled so the core and its driver share one port.
interface spi_reg_mux_n_if #(
    parameter int NUM_CH   = 8,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8
);
    logic                       cs_n;
    logic                       serial_in;
    logic [NUM_CH-1:0]          raw_serial_out;
    logic [DATA_W-1:0]          status_in;
    logic [NUM_REGS*DATA_W-1:0] cfg_regs;
    logic [NUM_CH-1:0]          ch_select;
    logic [DATA_W-1:0]          cmd_pulse;
    logic                       serial_out;

    modport master (
        output cs_n, serial_in, raw_serial_out, status_in,
        input  cfg_regs, ch_select, cmd_pulse, serial_out
    );

    modport slave (
        input  cs_n, serial_in, raw_serial_out, status_in,
        output cfg_regs, ch_select, cmd_pulse, serial_out
    );
endinterface

// File: rtl/spi_reg_mux_n.sv
// SPI slave register file with command pulses, burst access and a
// channel readout mux that streams one channel's serial bits to MISO.
module spi_reg_mux_n #(
    parameter int NUM_CH   = 8,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter logic [NUM_REGS*DATA_W-1:0] CFG_RESET = '0
) (
    input logic            sclk,
    input logic            rst,
    spi_reg_mux_n_if.slave bus
);
    localparam int ADDR_W = DATA_W - 2;
    localparam int CNT_W  = $clog2(DATA_W);

    localparam logic [ADDR_W-1:0] A_CH0  = ADDR_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NUM_REGS + NUM_CH);
    localparam logic [ADDR_W-1:0] A_CMD  = '1;
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    logic [2:0]                 r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [DATA_W-2:0]          r_shift;
    logic [DATA_W-1:0]          r_rd;
    logic [DATA_W-1:0]          r_cmd;
    logic [ADDR_W-1:0]          r_addr;
    logic                       r_w;
    logic                       r_b;
    logic                       r_sout;
    logic [NUM_CH-1:0]          r_ch_sel;
    logic [NUM_REGS*DATA_W-1:0] r_cfg;

    logic [DATA_W-1:0] w_word;
    logic [ADDR_W-1:0] w_new_addr;
    logic [DATA_W-1:0] w_new_rd;
    logic [NUM_CH-1:0] w_new_oh;
    logic              w_new_is_ch;
    logic              w_last;
    logic              w_commit;

    assign w_word   = {r_shift, bus.serial_in};
    assign w_last   = (r_cnt == LAST);
    assign w_commit = !bus.cs_n && (r_state == S_DATA) && w_last && r_w;

    // Address about to become current: header field or burst successor
    assign w_new_addr = (r_state == S_ADDR) ? w_word[ADDR_W-1:0]
                                            : r_addr + ADDR_W'(1);

    always_comb begin
        w_new_rd = '0;
        w_new_oh = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (w_new_addr == ADDR_W'(k))
                w_new_rd = r_cfg[k*DATA_W +: DATA_W];
        if (w_new_addr == A_STAT)
            w_new_rd = bus.status_in;
        for (int k = 0; k < NUM_CH; k++)
            w_new_oh[k] = (w_new_addr == ADDR_W'(NUM_REGS + k));
    end

    assign w_new_is_ch = (w_new_addr >= A_CH0) && (w_new_addr < A_STAT);

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_rd     <= '0;
            r_addr   <= '0;
            r_w      <= 1'b0;
            r_b      <= 1'b0;
            r_sout   <= 1'b0;
            r_ch_sel <= '0;
        end else if (bus.cs_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sout   <= 1'b0;
            r_ch_sel <= '0;
        end else begin
            r_shift <= w_word[DATA_W-2:0];
            case (r_state)
                S_IDLE: begin
                    r_state <= S_ADDR;
                    r_cnt   <= CNT_W'(1);
                end
                S_ADDR: begin
                    if (w_last) begin
                        r_addr   <= w_new_addr;
                        r_w      <= w_word[DATA_W-1];
                        r_b      <= w_word[DATA_W-2];
                        r_rd     <= w_new_rd;
                        r_cnt    <= '0;
                        r_ch_sel <= w_new_oh;
                        r_state  <= w_new_is_ch ? S_STREAM : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    r_sout <= r_rd[DATA_W-1];
                    r_rd   <= r_rd << 1;
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_b) begin
                            r_addr   <= w_new_addr;
                            r_rd     <= w_new_rd;
                            r_ch_sel <= w_new_oh;
                            r_state  <= w_new_is_ch ? S_STREAM : S_DATA;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STREAM: r_sout <= |(bus.raw_serial_out & r_ch_sel);
                S_HOLD:   r_sout <= 1'b0;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Write side: config registers and the self-clearing command word
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_cfg <= CFG_RESET;
            r_cmd <= '0;
        end else begin
            r_cmd <= (w_commit && r_addr == A_CMD) ? w_word : '0;
            for (int k = 0; k < NUM_REGS; k++)
                if (w_commit && r_addr == ADDR_W'(k))
                    r_cfg[k*DATA_W +: DATA_W] <= w_word;
        end
    end

    assign bus.cfg_regs   = r_cfg;
    assign bus.ch_select  = r_ch_sel;
    assign bus.cmd_pulse  = r_cmd;
    assign bus.serial_out = r_sout;
endmodule

// File: tb/tb_spi_reg_mux_n.sv
// Randomised + directed bench for spi_reg_mux_n: a word-level host
// model queues per-cycle expectations, a monitor pops and compares.
module tb_spi_reg_mux_n;
    localparam int NCH = 8;
    localparam int DW  = 8;
    localparam int NR  = 8;

    typedef struct {
        logic           so;
        logic [NCH-1:0] ch;
        logic [DW-1:0]  cmd;
        logic [NR*DW-1:0] cfg;
        int             fr;
        int             p;
    } exp_t;

    logic sclk = 1'b0;
    logic rst  = 1'b1;

    spi_reg_mux_n_if #(.NUM_CH(NCH), .DATA_W(DW), .NUM_REGS(NR)) bus ();

    spi_reg_mux_n #(
        .NUM_CH(NCH), .DATA_W(DW), .NUM_REGS(NR), .CFG_RESET('0)
    ) dut (
        .sclk(sclk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 sclk = ~sclk;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          frame_no = 0;
    logic [DW-1:0] m_cfg [NR];
    logic [DW-1:0] m_status;

    function automatic logic [NR*DW-1:0] flat();
        logic [NR*DW-1:0] v;
        for (int k = 0; k < NR; k++) v[k*DW +: DW] = m_cfg[k];
        return v;
    endfunction

    function automatic bit is_ch(input logic [5:0] a);
        return (int'(a) >= NR) && (int'(a) < NR + NCH);
    endfunction

    function automatic logic [NCH-1:0] onehot(input logic [5:0] a);
        logic [NCH-1:0] v;
        v = '0;
        v[int'(a) - NR] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] rd_val(input logic [5:0] a);
        if (int'(a) < NR) return m_cfg[a[2:0]];
        if (int'(a) == NR + NCH) return m_status;
        return '0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Monitor: one expectation per clock, sampled on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge sclk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (bus.serial_out !== e.so || bus.ch_select !== e.ch ||
                    bus.cmd_pulse !== e.cmd || bus.cfg_regs !== e.cfg) begin
                    n_bad++;
                    $display("FAIL frame%0d edge%0d: so %b/%b ch %h/%h cmd %h/%h cfg %h/%h (got/want)",
                             e.fr, e.p, bus.serial_out, e.so, bus.ch_select, e.ch,
                             bus.cmd_pulse, e.cmd, bus.cfg_regs, e.cfg);
                end
            end
        end
    end

    task automatic step(input logic cs, input logic si,
                        input logic [NCH-1:0] raw, input logic r,
                        input exp_t e);
        @(negedge sclk);
        #1;
        bus.cs_n           = cs;
        bus.serial_in      = si;
        bus.raw_serial_out = raw;
        rst                = r;
        q.push_back(e);
    endtask

    task automatic idle(input logic r);
        exp_t e;
        if (r) for (int k = 0; k < NR; k++) m_cfg[k] = '0;
        e.so = 1'b0; e.ch = '0; e.cmd = '0; e.cfg = flat();
        e.fr = frame_no; e.p = 0;
        step(1'b1, 1'b0, NCH'($urandom), r, e);
    endtask

    // Host frame: bytes[31:24] is the header; bits past 32 are random
    task automatic frame(input logic [31:0] bytes, input int nbits,
                         input int rst_at, input bit use_pat,
                         input logic [7:0] pat);
        logic [5:0]     a;
        logic           w, bu, si, so;
        logic [7:0]     rd, word, cmdv;
        logic [NCH-1:0] raw, chs;
        int             mode, j;
        exp_t           e;
        frame_no++;
        a = '0; w = 0; bu = 0; so = 0; rd = '0; word = '0;
        chs = '0; mode = 0; j = 0;
        for (int p = 1; p <= nbits; p++) begin
            si  = (p <= 32) ? bytes[5'(32 - p)] : 1'($urandom);
            raw = NCH'($urandom);
            if (use_pat && p >= 9 && p <= 16) raw[4] = pat[16 - p];
            e.fr = frame_no; e.p = p;
            if (p == rst_at) begin
                for (int k = 0; k < NR; k++) m_cfg[k] = '0;
                e.so = 1'b0; e.ch = '0; e.cmd = '0; e.cfg = flat();
                step(1'b0, si, raw, 1'b1, e);
                break;
            end
            cmdv = '0;
            if (p == DW) begin
                w = bytes[31]; bu = bytes[30]; a = bytes[29:24];
                if (is_ch(a)) begin
                    mode = 2; chs = onehot(a);
                end else begin
                    mode = 1; rd = rd_val(a); j = 0;
                end
            end else if (p > DW) begin
                if (mode == 2) begin
                    so = raw[int'(a) - NR];
                end else if (mode == 1) begin
                    so   = rd[7 - j];
                    word = {word[6:0], si};
                    j++;
                    if (j == 8) begin
                        if (w && int'(a) < NR) m_cfg[a[2:0]] = word;
                        if (w && a == 6'd63) cmdv = word;
                        if (bu) begin
                            a = a + 6'd1;
                            if (is_ch(a)) begin
                                mode = 2; chs = onehot(a);
                            end else begin
                                rd = rd_val(a); j = 0;
                            end
                        end else begin
                            mode = 3;
                        end
                    end
                end else begin
                    so = 1'b0;
                end
            end
            e.so = so; e.ch = chs; e.cmd = cmdv; e.cfg = flat();
            step(1'b0, si, raw, 1'b0, e);
        end
        idle(1'b0);
    endtask

    initial begin
        int nb, ra;
        bus.cs_n = 1'b1; bus.serial_in = 1'b0;
        bus.raw_serial_out = '0; bus.status_in = '0;
        m_status = '0;
        for (int k = 0; k < NR; k++) m_cfg[k] = '0;

        idle(1'b1);
        idle(1'b0);
        idle(1'b0);

        frame(32'h83AA_0000, 16, 11, 0, 8'h00);
        @(posedge sclk); #1;
        chk("reset_cfg", 64'(bus.cfg_regs), 64'h0);

        frame(32'h8304_0000, 16, 0, 0, 8'h00);
        @(posedge sclk); #1;
        chk("reg3_write", 64'(bus.cfg_regs[31:24]), 64'h04);
        frame(32'h03FF_0000, 16, 0, 0, 8'h00);
        @(posedge sclk); #1;
        chk("reg3_kept", 64'(bus.cfg_regs[31:24]), 64'h04);

        frame(32'hC211_2233, 32, 0, 0, 8'h00);
        @(posedge sclk); #1;
        chk("burst_regs", 64'(bus.cfg_regs[39:16]), 64'h332211);
        frame(32'h4200_0000, 32, 0, 0, 8'h00);
        frame(32'hC7AB_CD00, 32, 0, 0, 8'h00);
        @(posedge sclk); #1;
        chk("reg7_burst", 64'(bus.cfg_regs[63:56]), 64'hAB);

        frame(32'h0C00_0000, 32, 0, 1, 8'h33);

        m_status = 8'h01;
        bus.status_in = m_status;
        frame(32'h1000_0000, 16, 0, 0, 8'h00);
        frame(32'h90AA_0000, 16, 0, 0, 8'h00);

        frame(32'hBF02_0000, 16, 0, 0, 8'h00);
        frame(32'h8355_0000, 13, 0, 0, 8'h00);
        @(posedge sclk); #1;
        chk("abort_reg3", 64'(bus.cfg_regs[31:24]), 64'h22);

        for (int i = 0; i < 60; i++) begin
            m_status = DW'($urandom);
            bus.status_in = m_status;
            nb = $urandom_range(1, 40);
            ra = ($urandom_range(0, 9) == 0) ? $urandom_range(1, nb) : 0;
            frame($urandom, nb, ra, 0, 8'h00);
        end

        idle(1'b0);
        idle(1'b0);
        for (int i = 0; i < 5 && q.size() > 0; i++) begin
            @(negedge sclk);
            #2;
        end
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
